// File: rtl/frv_mdu_pkg.sv
// Shared definitions for the MDU issue logic.
// Holds the request op codes, the issue FSM state type and the mapping from
// an op code to the unit's one-hot op lines.
package frv_mdu_pkg;

  localparam logic [3:0] MDU_OP_MUL    = 4'd0;
  localparam logic [3:0] MDU_OP_MULH   = 4'd1;
  localparam logic [3:0] MDU_OP_MULHSU = 4'd2;
  localparam logic [3:0] MDU_OP_MULHU  = 4'd3;
  localparam logic [3:0] MDU_OP_DIV    = 4'd4;
  localparam logic [3:0] MDU_OP_DIVU   = 4'd5;
  localparam logic [3:0] MDU_OP_REM    = 4'd6;
  localparam logic [3:0] MDU_OP_REMU   = 4'd7;
  localparam logic [3:0] MDU_OP_CLMUL  = 4'd8;
  localparam logic [3:0] MDU_OP_CLMULH = 4'd9;
  localparam logic [3:0] MDU_OP_CLMULR = 4'd10;

  localparam int unsigned MDU_OP_NUM = 11;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StClr,
    StResp
  } mdu_state_e;

  // Codes above MDU_OP_CLMULR are illegal and map to no op line.
  function automatic logic [MDU_OP_NUM-1:0] mdu_op_onehot(input logic [3:0] op);
    logic [MDU_OP_NUM-1:0] oh;
    oh = '0;
    if (op <= MDU_OP_CLMULR) begin
      oh = {{(MDU_OP_NUM-1){1'b0}}, 1'b1} << op;
    end
    return oh;
  endfunction

endpackage

// File: rtl/frv_mdu_fastpath.sv
// Combinational resolver for requests that never need the MDU.
// Ports:
//   req_op, req_rs1, req_rs2 : encoded request and operands
//   hit                      : request resolved here
//   err                      : resolved as an error (illegal op)
//   result                   : resolved result value
module frv_mdu_fastpath
  import frv_mdu_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [3:0]      req_op,
  input  logic [XLEN-1:0] req_rs1,
  input  logic [XLEN-1:0] req_rs2,
  output logic            hit,
  output logic            err,
  output logic [XLEN-1:0] result
);

  localparam logic [XLEN-1:0] MinNeg = {1'b1, {(XLEN-1){1'b0}}};

  logic rs2_zero;
  logic div_ovf;

  assign rs2_zero = (req_rs2 == '0);
  // Most-negative / -1 overflows signed division.
  assign div_ovf  = (req_rs1 == MinNeg) && (req_rs2 == '1);

  always_comb begin
    hit    = 1'b0;
    err    = 1'b0;
    result = '0;
    if (req_op > MDU_OP_CLMULR) begin
      hit = 1'b1;
      err = 1'b1;
    end else if ((req_op == MDU_OP_DIV || req_op == MDU_OP_DIVU) && rs2_zero) begin
      hit    = 1'b1;
      result = '1;
    end else if ((req_op == MDU_OP_REM || req_op == MDU_OP_REMU) && rs2_zero) begin
      hit    = 1'b1;
      result = req_rs1;
    end else if (req_op == MDU_OP_DIV && div_ovf) begin
      hit    = 1'b1;
      result = MinNeg;
    end else if (req_op == MDU_OP_REM && div_ovf) begin
      hit    = 1'b1;
      result = '0;
    end
  end

endmodule

// File: rtl/frv_mdu_issue.sv
// Execute-stage initiator for the multi-cycle mul/div/clmul unit.
// Accepts a request, resolves trivial cases locally, otherwise drives the
// unit until ready, captures the result, flushes the unit and hands the
// result to writeback.
// Ports:
//   g_clk, g_resetn          : clock, async active-low reset
//   flush                    : pipeline flush, abandons any operation
//   req_valid/ready/op/rs1/rs2 : request handshake and payload
//   mdu_valid/flush/op/rs1/rs2 : drive to the unit
//   mdu_ready, mdu_rd        : unit result (ready held until flushed)
//   rsp_valid/ready/rd/err   : writeback handshake and payload
module frv_mdu_issue
  import frv_mdu_pkg::*;
#(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned MDU_TIMEOUT = 100
) (
  input  logic                  g_clk,
  input  logic                  g_resetn,
  input  logic                  flush,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [3:0]            req_op,
  input  logic [XLEN-1:0]       req_rs1,
  input  logic [XLEN-1:0]       req_rs2,
  output logic                  mdu_valid,
  output logic                  mdu_flush,
  output logic [MDU_OP_NUM-1:0] mdu_op,
  output logic [XLEN-1:0]       mdu_rs1,
  output logic [XLEN-1:0]       mdu_rs2,
  input  logic                  mdu_ready,
  input  logic [XLEN-1:0]       mdu_rd,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [XLEN-1:0]       rsp_rd,
  output logic                  rsp_err
);

  localparam int unsigned CntW = (MDU_TIMEOUT > 2) ? $clog2(MDU_TIMEOUT) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(MDU_TIMEOUT - 1);

  mdu_state_e      state_q, state_d;
  logic [3:0]      op_q, op_d;
  logic [XLEN-1:0] rs1_q, rs1_d;
  logic [XLEN-1:0] rs2_q, rs2_d;
  logic [XLEN-1:0] rd_q, rd_d;
  logic            err_q, err_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic            fp_hit;
  logic            fp_err;
  logic [XLEN-1:0] fp_result;

  frv_mdu_fastpath #(
    .XLEN (XLEN)
  ) u_fastpath (
    .req_op  (req_op),
    .req_rs1 (req_rs1),
    .req_rs2 (req_rs2),
    .hit     (fp_hit),
    .err     (fp_err),
    .result  (fp_result)
  );

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      state_q <= StIdle;
      op_q    <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      rd_q    <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      rd_q    <= rd_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    rs1_d   = rs1_q;
    rs2_d   = rs2_q;
    rd_d    = rd_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    if (flush) begin
      // Flush wins over accept, unit ready and writeback handshake alike.
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req_valid) begin
            if (fp_hit) begin
              rd_d    = fp_result;
              err_d   = fp_err;
              state_d = StResp;
            end else begin
              op_d    = req_op;
              rs1_d   = req_rs1;
              rs2_d   = req_rs2;
              cnt_d   = '0;
              err_d   = 1'b0;
              state_d = StRun;
            end
          end
        end
        StRun: begin
          if (mdu_ready) begin
            rd_d    = mdu_rd;
            err_d   = 1'b0;
            state_d = StClr;
          end else if (cnt_q == CntMax) begin
            rd_d    = '0;
            err_d   = 1'b1;
            state_d = StClr;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        StClr:   state_d = StResp;
        StResp:  if (rsp_ready) state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    req_ready = (state_q == StIdle) && !flush;
    mdu_valid = (state_q == StRun);
    mdu_op    = mdu_valid ? mdu_op_onehot(op_q) : '0;
    mdu_rs1   = rs1_q;
    mdu_rs2   = rs2_q;
    // CLR re-arms the unit so it is never re-requested while holding a result.
    mdu_flush = flush || (state_q == StClr);
    rsp_valid = (state_q == StResp);
    rsp_rd    = rd_q;
    rsp_err   = err_q;
  end

endmodule
